uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_sync_fifo.sv | 77 +++++++
 rtl/uart_rx_fifo.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared receiver state encoding and per-frame status record.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP       = 3'd4,
        ST_PUSH       = 3'd5,
        ST_BREAK_WAIT = 3'd6
    } rx_state_t;

    // 'break' is a reserved word, hence brk
    typedef struct packed {
        logic brk;
        logic frame_err;
        logic parity_err;
    } rx_status_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync_fifo
//  Description : First-word-fall-through FIFO with registered overflow pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       valid,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH + 1);
    localparam logic [c_LVL_W-1:0] c_FULL = c_LVL_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_count;
    logic               r_overflow;

    logic w_empty;
    logic w_full;
    logic w_rd;
    logic w_wr;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);
    assign w_rd    = rd_en & ~w_empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_wr    = wr_en & (~w_full | w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= wr_en & ~w_wr;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_LVL_W'(1);
                2'b01:   r_count <= r_count - c_LVL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign valid    = ~w_empty;
    assign overflow = r_overflow;
    assign level    = r_count;

endmodule : uart_sync_fifo
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Oversampled UART receiver with majority-vote bit recovery,
//                parity/framing/break detection and a FWFT frame buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int OVERSAMPLING = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            rx,
    input  logic                            parity_en,
    input  logic                            parity_type,
    input  logic                            stop2,
    output logic [DATA_WIDTH-1:0]           m_data,
    output logic                            m_parity_err,
    output logic                            m_frame_err,
    output logic                            m_break,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic                            overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

    localparam int c_CNT_W   = $clog2(OVERSAMPLING);
    localparam int c_BIT_W   = $clog2(DATA_WIDTH);
    localparam int c_ENTRY_W = DATA_WIDTH + 3;
    localparam logic [c_CNT_W-1:0] c_VOTE_A   = c_CNT_W'(OVERSAMPLING / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_VOTE_B   = c_CNT_W'(OVERSAMPLING / 2);
    localparam logic [c_CNT_W-1:0] c_VOTE_C   = c_CNT_W'(OVERSAMPLING / 2 + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(OVERSAMPLING - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_WIDTH - 1);

    rx_state_t             r_state;
    rx_state_t             w_next;
    logic [1:0]            r_sync;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_samp_a;
    logic                  r_samp_b;
    logic [c_BIT_W-1:0]    r_bit_idx;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_bit;
    logic                  r_stop_idx;
    logic                  r_stop1;
    logic                  r_par_en;
    logic                  r_par_type;
    logic                  r_stop2;
    rx_status_t            r_status;

    logic                  w_rxs;
    logic                  w_vote_now;
    logic                  w_vote;
    logic                  w_wrap;
    logic                  w_first_stop;
    logic                  w_push;
    rx_status_t            w_status;
    rx_status_t            w_head_status;
    logic [c_ENTRY_W-1:0]  w_head;

    assign w_rxs      = r_sync[1];
    assign w_vote_now = (r_cnt == c_VOTE_C);
    assign w_wrap     = (r_cnt == c_CNT_MAX);
    assign w_vote     = (r_samp_a & r_samp_b) | (r_samp_a & w_rxs) | (r_samp_b & w_rxs);

    // Status as it would stand if the current stop vote were the last one
    assign w_first_stop        = r_stop_idx ? r_stop1 : w_vote;
    assign w_status.brk        = (r_data == '0) && !(r_par_en && r_par_bit) && !w_first_stop;
    assign w_status.frame_err  = ~w_vote | ~w_first_stop;
    assign w_status.parity_err = r_par_en & (^r_data ^ r_par_bit ^ r_par_type);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync  <= 2'b11;
            r_state <= ST_IDLE;
        end else begin
            r_sync  <= {r_sync[0], rx};
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_push = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_rxs) w_next = ST_START;
            end
            ST_START: begin
                if (w_vote_now && w_vote) w_next = ST_IDLE;
                else if (w_wrap)          w_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_wrap && (r_bit_idx == c_LAST_BIT)) w_next = r_par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (w_wrap) w_next = ST_STOP;
            end
            ST_STOP: begin
                // leave mid-bit so a back-to-back start edge is seen from IDLE
                if (w_vote_now && (r_stop_idx == r_stop2)) w_next = ST_PUSH;
            end
            ST_PUSH: begin
                w_push = 1'b1;
                w_next = r_status.brk ? ST_BREAK_WAIT : ST_IDLE;
            end
            ST_BREAK_WAIT: begin
                if (w_rxs) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_samp_a   <= 1'b1;
            r_samp_b   <= 1'b1;
            r_bit_idx  <= '0;
            r_data     <= '0;
            r_par_bit  <= 1'b0;
            r_stop_idx <= 1'b0;
            r_stop1    <= 1'b1;
            r_par_en   <= 1'b0;
            r_par_type <= 1'b0;
            r_stop2    <= 1'b0;
            r_status   <= '0;
        end else begin
            if ((r_state == ST_IDLE) || (r_state == ST_PUSH) ||
                (r_state == ST_BREAK_WAIT) || w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            if (r_cnt == c_VOTE_A) r_samp_a <= w_rxs;
            if (r_cnt == c_VOTE_B) r_samp_b <= w_rxs;

            case (r_state)
                ST_IDLE: begin
                    r_bit_idx  <= '0;
                    r_stop_idx <= 1'b0;
                    if (!w_rxs) begin
                        r_par_en   <= parity_en;
                        r_par_type <= parity_type;
                        r_stop2    <= stop2;
                    end
                end
                ST_DATA: begin
                    if (w_vote_now) r_data <= {w_vote, r_data[DATA_WIDTH-1:1]};
                    if (w_wrap)     r_bit_idx <= r_bit_idx + c_BIT_W'(1);
                end
                ST_PARITY: begin
                    if (w_vote_now) r_par_bit <= w_vote;
                end
                ST_STOP: begin
                    if (w_vote_now) begin
                        r_stop_idx <= 1'b1;
                        r_stop1    <= w_first_stop;
                        r_status   <= w_status;
                    end
                end
                default: ;
            endcase
        end
    end

    uart_sync_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (w_push),
        .wr_data  ({r_status, r_data}),
        .rd_en    (m_ready),
        .rd_data  (w_head),
        .valid    (m_valid),
        .overflow (overrun),
        .level    (fifo_level)
    );

    assign {w_head_status, m_data} = w_head;
    assign m_break      = w_head_status.brk;
    assign m_frame_err  = w_head_status.frame_err;
    assign m_parity_err = w_head_status.parity_err;

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo (8 data bits, x16, depth 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int c_OS = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       parity_en;
    logic       parity_type;
    logic       stop2;
    logic [7:0] m_data;
    logic       m_parity_err;
    logic       m_frame_err;
    logic       m_break;
    logic       m_valid;
    logic       m_ready;
    logic       overrun;
    logic [2:0] fifo_level;

    uart_rx_fifo #(
        .DATA_WIDTH   (8),
        .OVERSAMPLING (c_OS),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .parity_en    (parity_en),
        .parity_type  (parity_type),
        .stop2        (stop2),
        .m_data       (m_data),
        .m_parity_err (m_parity_err),
        .m_frame_err  (m_frame_err),
        .m_break      (m_break),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .overrun      (overrun),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       brk;
        logic       fe;
        logic       pe;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       pen;
        logic       ptype;
        logic       s2;
        logic       pflip;
        logic       sbad;
        logic       pe;
        logic       fe;
        logic       brk;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_fail = 0;
    int   ovr_cnt = 0;
    int   valid_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (overrun) ovr_cnt++;
        if (m_valid) valid_cycles++;
        if (!reset && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got %0h required no entry", m_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pop_data", {24'd0, m_data}, {24'd0, e.data});
                check("pop_flags", {29'd0, m_break, m_frame_err, m_parity_err},
                      {29'd0, e.brk, e.fe, e.pe});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(c_OS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptype,
                              input logic s2, input logic pflip, input logic sbad);
        parity_en   = pen;
        parity_type = ptype;
        stop2       = s2;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pen) send_bit(^d ^ ptype ^ pflip);
        send_bit(!sbad);
        if (s2) send_bit(1'b1);
        rx = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) tick(1);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int lat;
        int vc0;

        //          data   pen ptype s2 pflip sbad  pe fe brk
        vecs[0] = '{8'hA5, 0,  0,    0, 0,    0,    0, 0, 0};
        vecs[1] = '{8'h3C, 1,  0,    1, 1,    0,    1, 0, 0};
        vecs[2] = '{8'h00, 1,  1,    0, 0,    0,    0, 0, 0};
        vecs[3] = '{8'hFF, 1,  0,    0, 0,    0,    0, 0, 0};
        vecs[4] = '{8'h5A, 0,  0,    0, 0,    1,    0, 1, 0};
        vecs[5] = '{8'h81, 1,  1,    1, 1,    0,    1, 0, 0};
        vecs[6] = '{8'h00, 0,  0,    0, 0,    1,    0, 1, 1};
        vecs[7] = '{8'h00, 1,  0,    0, 1,    1,    1, 1, 0};

        reset = 1'b1; rx = 1'b1; m_ready = 1'b0;
        parity_en = 1'b0; parity_type = 1'b0; stop2 = 1'b0;
        tick(3);
        check("rst_valid", {31'd0, m_valid}, 0);
        check("rst_level", {29'd0, fifo_level}, 0);
        check("rst_data", {24'd0, m_data}, 0);
        check("rst_flags", {28'd0, overrun, m_break, m_frame_err, m_parity_err}, 0);
        reset = 1'b0;
        tick(4);

        // 8N1 0xA5: exact first-valid latency and a single valid cycle
        m_ready = 1'b1;
        vc0 = valid_cycles;
        exp_q.push_back('{8'hA5, 1'b0, 1'b0, 1'b0});
        lat = 0;
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            begin
                while (!m_valid && lat < 400) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check("valid_latency", lat, 159);
        tick(2 * c_OS);
        drain("a5_drain");
        check("a5_valid_pulses", valid_cycles - vc0, 1);

        for (int v = 0; v < 8; v++) begin
            exp_q.push_back('{vecs[v].data, vecs[v].brk, vecs[v].fe, vecs[v].pe});
            send_frame(vecs[v].data, vecs[v].pen, vecs[v].ptype, vecs[v].s2,
                       vecs[v].pflip, vecs[v].sbad);
            tick(2 * c_OS);
            drain("vec_drain");
        end

        // short low glitch must be rejected as a false start
        vc0 = valid_cycles;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(4 * c_OS);
        check("glitch_level", {29'd0, fifo_level}, 0);
        check("glitch_valid", valid_cycles - vc0, 0);

        // line break: one entry only until the line returns high
        m_ready = 1'b0;
        parity_en = 1'b0; stop2 = 1'b0;
        rx = 1'b0;
        tick(20 * c_OS);
        check("break_level", {29'd0, fifo_level}, 1);
        rx = 1'b1;
        tick(2 * c_OS);
        check("break_hold_level", {29'd0, fifo_level}, 1);
        exp_q.push_back('{8'h00, 1'b1, 1'b1, 1'b0});
        send_frame(8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(2 * c_OS);
        check("after_break_level", {29'd0, fifo_level}, 2);
        exp_q.push_back('{8'h42, 1'b0, 1'b0, 1'b0});
        m_ready = 1'b1;
        drain("break_drain");
        m_ready = 1'b0;

        // overrun: five frames into a four-entry buffer
        ovr_cnt = 0;
        for (int v = 1; v <= 5; v++) begin
            send_frame(8'(v), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick(2 * c_OS);
        end
        check("ovr_level", {29'd0, fifo_level}, 4);
        check("ovr_pulses", ovr_cnt, 1);
        for (int v = 1; v <= 4; v++) exp_q.push_back('{8'(v), 1'b0, 1'b0, 1'b0});
        m_ready = 1'b1;
        drain("ovr_drain");
        check("ovr_empty_level", {29'd0, fifo_level}, 0);

        // reset mid-frame clears a stored entry and the partial 0x55
        m_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(2 * c_OS);
        check("pre_rst_level", {29'd0, fifo_level}, 1);
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        rx = 1'b1;
        tick(5);
        reset = 1'b1;
        tick(2);
        check("midrst_level", {29'd0, fifo_level}, 0);
        check("midrst_out", {23'd0, m_valid, m_data}, 0);
        check("midrst_flags", {28'd0, overrun, m_break, m_frame_err, m_parity_err}, 0);
        reset = 1'b0;
        tick(3 * c_OS);
        check("post_rst_level", {29'd0, fifo_level}, 0);
        exp_q.push_back('{8'h66, 1'b0, 1'b0, 1'b0});
        send_frame(8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(2 * c_OS);
        check("post_rst_frame_level", {29'd0, fifo_level}, 1);
        m_ready = 1'b1;
        drain("rst_drain");
        tick(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_rx_fifo
`default_nettype wire
